// File: rtl/bnn_host_pkg.sv
// Definitions for the binary-NN dot-product CFU-L2 initiator: job FSM state
// encoding, the dot-product function ID and the response-wait timeout limit.
package bnn_host_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bnn_host_state_e;

  localparam logic [cfu_pkg::FUNC_ID_W-1:0] BNN_DOT_FUNC_ID = '0;

  // Wait-counter value at which a stalled job is abandoned (optional feature).
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;
endpackage

// File: rtl/cfu_pkg.sv
// Shared CFU-L2 definitions: response status encoding and the width of the
// function-ID field carried on the request channel.
package cfu_pkg;
  localparam int STATUS_W  = 2;
  localparam int FUNC_ID_W = 10;

  localparam logic [STATUS_W-1:0] CFU_STATUS_OK  = 2'd0;
  localparam logic [STATUS_W-1:0] CFU_STATUS_ERR = 2'd1;
endpackage

// File: rtl/bnn_host_credit.sv
// Outstanding-request credit counter for the CFU-L2 initiator.
//
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_clr           clear the count (new job accepted)
//   i_inc           request handshake (one more request outstanding)
//   i_dec           response handshake (one request retired)
//   i_held          a request is sitting in the output register, not yet
//                   accepted; it already owns a credit
//   o_can_issue     a new operand beat may be loaded without ever letting
//                   the outstanding count exceed MAX_OUT
//   o_count         current number of unanswered requests
module bnn_host_credit #(
  parameter int MAX_OUT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_held,
  output logic       o_can_issue,
  output logic [3:0] o_count
);
  localparam logic [4:0] MAX5 = 5'(MAX_OUT);

  logic [3:0] r_cnt;

  // Saturating at both ends; simultaneous inc and dec cancel.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != MAX5[3:0])) begin
      r_cnt <= r_cnt + 4'd1;
    end else if (i_dec && !i_inc && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // The held request counts against the budget: once it handshakes it
  // becomes outstanding, and it cannot be withdrawn.
  assign o_can_issue = ({1'b0, r_cnt} + {4'd0, i_held}) < MAX5;
  assign o_count     = r_cnt;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_inc && !i_dec && !i_clr && (r_cnt == MAX5[3:0])));
endmodule

// File: rtl/bnn_l2_host.sv
// CFU-L2 initiator for the binary-NN dot-product CFU. Accepts a job length,
// streams operand pairs as CFU-L2 requests with a bounded number in flight,
// and accumulates the per-word popcount(xnor) responses into a scalar sum.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   clk_en                    CFU clock enable (high whenever not IDLE)
//   cmd_valid/ready, cmd_len  job start handshake and word-pair count
//   in_valid/ready, in_a/b    operand pair stream
//   req_valid/ready, req_func, req_data0/1   CFU-L2 request channel
//   resp_valid/ready, resp_status, resp_data CFU-L2 response channel
//   done                      one-cycle pulse at job completion
//   sum                       dot-product result, held until next job
//   err                       sticky: a response reported non-OK status
//   dbg_state                 FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// valid source holds its payload stable until that edge.
//
// Optional feature macro: BNN_L2_HOST_TIMEOUT_EN adds a response-wait
// timeout that ends a stuck job with err set and the partial sum.
module bnn_l2_host
  import cfu_pkg::*;
  import bnn_host_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SUM_W   = 32,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 4,
  parameter logic [FUNC_ID_W-1:0] FUNC_ID = BNN_DOT_FUNC_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 clk_en,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_a,
  input  logic [DATA_W-1:0]    in_b,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [FUNC_ID_W-1:0] req_func,
  output logic [DATA_W-1:0]    req_data0,
  output logic [DATA_W-1:0]    req_data1,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  input  logic [STATUS_W-1:0]  resp_status,
  input  logic [DATA_W-1:0]    resp_data,
  output logic                 done,
  output logic [SUM_W-1:0]     sum,
  output logic                 err,
  output logic [1:0]           dbg_state
);
  bnn_host_state_e r_state, w_state_nxt;

  logic              r_alive;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_retired;
  logic [SUM_W-1:0]  r_sum;
  logic              r_err;
  logic              r_req_valid;
  logic [DATA_W-1:0] r_req_d0;
  logic [DATA_W-1:0] r_req_d1;

  logic       w_cmd_hs;
  logic       w_in_hs;
  logic       w_req_hs;
  logic       w_resp_hs;
  logic       w_can_issue;
  logic [3:0] w_out_cnt;
  logic       w_timeout;

  assign w_req_hs  = r_req_valid && req_ready;
  assign w_resp_hs = resp_valid && resp_ready;
  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_in_hs   = in_valid && in_ready;

  // r_alive keeps cmd_ready low for the first cycle out of reset, so every
  // handshake output reads 0 while and right after reset is applied.
  assign cmd_ready  = (r_state == IDLE) && r_alive;
  assign in_ready   = (r_state == RUN) && (r_issued < r_len) && w_can_issue &&
                      (!r_req_valid || req_ready);
  assign resp_ready = (r_state == RUN) || (r_state == DRAIN);
  assign clk_en     = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign req_valid  = r_req_valid;
  assign req_func   = FUNC_ID;
  assign req_data0  = r_req_d0;
  assign req_data1  = r_req_d1;
  assign sum        = r_sum;
  assign err        = r_err;
  assign dbg_state  = r_state;

  bnn_host_credit #(.MAX_OUT(MAX_OUT)) u_credit (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_clr       (w_cmd_hs),
    .i_inc       (w_req_hs),
    .i_dec       (w_resp_hs),
    .i_held      (r_req_valid),
    .o_can_issue (w_can_issue),
    .o_count     (w_out_cnt)
  );

`ifdef BNN_L2_HOST_TIMEOUT_EN
  logic [15:0] r_wait;

  assign w_timeout = ((r_state == RUN) || (r_state == DRAIN)) && (r_wait == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (w_resp_hs || w_cmd_hs) begin
      r_wait <= '0;
    end else if (((r_state == RUN) || (r_state == DRAIN)) && (w_out_cnt != 4'd0) &&
                 (r_wait != TIMEOUT_LIMIT)) begin
      r_wait <= r_wait + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_state_nxt = RUN;
      RUN:     if (r_issued == r_len) w_state_nxt = DRAIN;
      DRAIN:   if (r_retired == r_len) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_alive     <= 1'b0;
      r_len       <= '0;
      r_issued    <= '0;
      r_retired   <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_d0    <= '0;
      r_req_d1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;

      if (w_cmd_hs) begin
        r_len     <= cmd_len;
        r_issued  <= '0;
        r_retired <= '0;
        r_sum     <= '0;
        r_err     <= 1'b0;
      end else begin
        if (w_in_hs) r_issued <= r_issued + LEN_W'(1);
        if (w_resp_hs) begin
          r_retired <= r_retired + LEN_W'(1);
          r_sum     <= r_sum + SUM_W'(resp_data);
          if (resp_status != CFU_STATUS_OK) r_err <= 1'b1;
        end
        if (w_timeout) r_err <= 1'b1;
      end

      // A new beat may replace a request accepted on this same edge.
      if (w_in_hs) begin
        r_req_valid <= 1'b1;
        r_req_d0    <= in_a;
        r_req_d1    <= in_b;
      end else if (w_req_hs) begin
        r_req_valid <= 1'b0;
      end
      // An abandoned job must not leave a request dangling into IDLE.
      if (w_timeout) r_req_valid <= 1'b0;
    end
  end

  a_resp_when_idle: assert property (@(posedge clk) disable iff (!rst)
    !(resp_valid && ((r_state == IDLE) || (r_state == DONE))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    w_resp_hs |-> ((w_out_cnt != 4'd0) || w_req_hs));
endmodule
